// File: rtl/adma_chn_mgmt.sv
`default_nettype none
// ============================================================================
// Module : adma_chn_mgmt
// Brief  : Round-robin descriptor issue to the DMA transfer engine, one
//          descriptor outstanding at a time, with per-channel done reporting.
// Rev    : 1.0  initial release
// ============================================================================
module adma_chn_mgmt #(
   parameter  int DMA_WR_CHN_NUM = 4,
   parameter  int SRC_ADDR_W     = 32,
   parameter  int DST_ADDR_W     = 32,
   parameter  int DMA_LENGTH_W   = 16,
   localparam int CHN_ID_W       = $clog2(DMA_WR_CHN_NUM)
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         mgmt_en_i,
   input  logic [DMA_WR_CHN_NUM-1:0]                    chn_en_i,
   input  logic [DMA_WR_CHN_NUM-1:0][SRC_ADDR_W-1:0]    src_addr_i,
   input  logic [DMA_WR_CHN_NUM-1:0][DST_ADDR_W-1:0]    dst_addr_i,
   input  logic [DMA_WR_CHN_NUM-1:0][DMA_LENGTH_W-1:0]  xfer_xlen_i,
   input  logic [DMA_WR_CHN_NUM-1:0][DMA_LENGTH_W-1:0]  xfer_ylen_i,
   input  logic [DMA_WR_CHN_NUM-1:0][DMA_LENGTH_W-1:0]  src_stride_i,
   input  logic [DMA_WR_CHN_NUM-1:0][DMA_LENGTH_W-1:0]  dst_stride_i,
   input  logic [DMA_WR_CHN_NUM-1:0]                    desc_rd_rdy_i,
   output logic [DMA_WR_CHN_NUM-1:0]                    desc_rd_vld_o,
   output logic                                         xfer_vld_o,
   input  logic                                         xfer_rdy_i,
   output logic [CHN_ID_W-1:0]                          xfer_chn_id_o,
   output logic [SRC_ADDR_W-1:0]                        xfer_src_addr_o,
   output logic [DST_ADDR_W-1:0]                        xfer_dst_addr_o,
   output logic [DMA_LENGTH_W-1:0]                      xfer_xlen_o,
   output logic [DMA_LENGTH_W-1:0]                      xfer_ylen_o,
   output logic [DMA_LENGTH_W-1:0]                      xfer_src_stride_o,
   output logic [DMA_LENGTH_W-1:0]                      xfer_dst_stride_o,
   input  logic                                         xfer_done_i,
   output logic [DMA_WR_CHN_NUM-1:0]                    chn_busy_o,
   output logic [DMA_WR_CHN_NUM-1:0]                    chn_done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [CHN_ID_W-1:0]       r_last_grant;
   logic [CHN_ID_W-1:0]       r_chn_id;
   logic [SRC_ADDR_W-1:0]     r_src_addr;
   logic [DST_ADDR_W-1:0]     r_dst_addr;
   logic [DMA_LENGTH_W-1:0]   r_xlen;
   logic [DMA_LENGTH_W-1:0]   r_ylen;
   logic [DMA_LENGTH_W-1:0]   r_src_stride;
   logic [DMA_LENGTH_W-1:0]   r_dst_stride;

   logic [DMA_WR_CHN_NUM-1:0] w_req;
   logic [CHN_ID_W-1:0]       w_gnt_id;
   logic                      w_gnt_found;
   logic                      w_grant;
   logic                      w_zero_len;

   function automatic logic [CHN_ID_W-1:0] wrap_add(input logic [CHN_ID_W-1:0] base,
                                                    input int ofs);
      int sum;
      sum = int'(base) + ofs;
      if (sum >= DMA_WR_CHN_NUM) sum = sum - DMA_WR_CHN_NUM;
      return CHN_ID_W'(sum);
   endfunction

   assign w_req = desc_rd_rdy_i & chn_en_i;

   // Search upward from the channel after the last grant; last_grant itself is checked last.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_id    = '0;
      for (int i = 1; i <= DMA_WR_CHN_NUM; i++) begin
         if (!w_gnt_found && w_req[wrap_add(r_last_grant, i)]) begin
            w_gnt_found = 1'b1;
            w_gnt_id    = wrap_add(r_last_grant, i);
         end
      end
   end

   assign w_grant    = (r_state == IDLE) && mgmt_en_i && w_gnt_found;
   assign w_zero_len = (xfer_xlen_i[w_gnt_id] == '0) || (xfer_ylen_i[w_gnt_id] == '0);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_grant)     w_state_nxt = w_zero_len ? DONE : ISSUE;
         ISSUE:   if (xfer_rdy_i)  w_state_nxt = BUSY;
         BUSY:    if (xfer_done_i) w_state_nxt = DONE;
         DONE:                     w_state_nxt = IDLE;
         default:                  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= CHN_ID_W'(DMA_WR_CHN_NUM - 1);
         r_chn_id     <= '0;
         r_src_addr   <= '0;
         r_dst_addr   <= '0;
         r_xlen       <= '0;
         r_ylen       <= '0;
         r_src_stride <= '0;
         r_dst_stride <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_last_grant <= w_gnt_id;
            r_chn_id     <= w_gnt_id;
            r_src_addr   <= src_addr_i[w_gnt_id];
            r_dst_addr   <= dst_addr_i[w_gnt_id];
            r_xlen       <= xfer_xlen_i[w_gnt_id];
            r_ylen       <= xfer_ylen_i[w_gnt_id];
            r_src_stride <= src_stride_i[w_gnt_id];
            r_dst_stride <= dst_stride_i[w_gnt_id];
         end
      end
   end

   // The pop strobe is combinational, so it is also masked while reset is held.
   always_comb begin
      desc_rd_vld_o = '0;
      chn_busy_o    = '0;
      chn_done_o    = '0;
      for (int c = 0; c < DMA_WR_CHN_NUM; c++) begin
         desc_rd_vld_o[c] = rst_n && w_grant && (w_gnt_id == CHN_ID_W'(c));
         chn_busy_o[c]    = (r_state != IDLE) && (r_chn_id == CHN_ID_W'(c));
         chn_done_o[c]    = (r_state == DONE) && (r_chn_id == CHN_ID_W'(c));
      end
   end

   assign xfer_vld_o        = (r_state == ISSUE);
   assign xfer_chn_id_o     = r_chn_id;
   assign xfer_src_addr_o   = r_src_addr;
   assign xfer_dst_addr_o   = r_dst_addr;
   assign xfer_xlen_o       = r_xlen;
   assign xfer_ylen_o       = r_ylen;
   assign xfer_src_stride_o = r_src_stride;
   assign xfer_dst_stride_o = r_dst_stride;

endmodule
`default_nettype wire

// File: tb/tb_adma_chn_mgmt.sv
`default_nettype none
// ============================================================================
// Module : tb_adma_chn_mgmt
// Brief  : Self-checking bench for adma_chn_mgmt (vector table, directed
//          corner sequences, randomized run against a transaction model).
// Rev    : 1.0  initial release
// ============================================================================
module tb_adma_chn_mgmt;
   localparam int N  = 4;
   localparam int SA = 32;
   localparam int DA = 32;
   localparam int LW = 16;
   localparam int IW = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  mgmt_en_i;
   logic [N-1:0]          chn_en_i, desc_rd_rdy_i, desc_rd_vld_o, chn_busy_o, chn_done_o;
   logic [N-1:0][SA-1:0]  src_addr_i;
   logic [N-1:0][DA-1:0]  dst_addr_i;
   logic [N-1:0][LW-1:0]  xfer_xlen_i, xfer_ylen_i, src_stride_i, dst_stride_i;
   logic                  xfer_vld_o, xfer_rdy_i, xfer_done_i;
   logic [IW-1:0]         xfer_chn_id_o;
   logic [SA-1:0]         xfer_src_addr_o;
   logic [DA-1:0]         xfer_dst_addr_o;
   logic [LW-1:0]         xfer_xlen_o, xfer_ylen_o, xfer_src_stride_o, xfer_dst_stride_o;

   always #5 clk = ~clk;

   adma_chn_mgmt #(
      .DMA_WR_CHN_NUM (N),
      .SRC_ADDR_W     (SA),
      .DST_ADDR_W     (DA),
      .DMA_LENGTH_W   (LW)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .mgmt_en_i         (mgmt_en_i),
      .chn_en_i          (chn_en_i),
      .src_addr_i        (src_addr_i),
      .dst_addr_i        (dst_addr_i),
      .xfer_xlen_i       (xfer_xlen_i),
      .xfer_ylen_i       (xfer_ylen_i),
      .src_stride_i      (src_stride_i),
      .dst_stride_i      (dst_stride_i),
      .desc_rd_rdy_i     (desc_rd_rdy_i),
      .desc_rd_vld_o     (desc_rd_vld_o),
      .xfer_vld_o        (xfer_vld_o),
      .xfer_rdy_i        (xfer_rdy_i),
      .xfer_chn_id_o     (xfer_chn_id_o),
      .xfer_src_addr_o   (xfer_src_addr_o),
      .xfer_dst_addr_o   (xfer_dst_addr_o),
      .xfer_xlen_o       (xfer_xlen_o),
      .xfer_ylen_o       (xfer_ylen_o),
      .xfer_src_stride_o (xfer_src_stride_o),
      .xfer_dst_stride_o (xfer_dst_stride_o),
      .xfer_done_i       (xfer_done_i),
      .chn_busy_o        (chn_busy_o),
      .chn_done_o        (chn_done_o)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   typedef struct {
      logic          mg;
      logic [N-1:0]  en;
      logic [N-1:0]  rq;
      logic          xr;
      logic          dn;
      logic [N-1:0]  pop;
      logic          vld;
      logic [IW-1:0] id;
      logic [N-1:0]  busy;
      logic [N-1:0]  done;
   } vec_t;

   function automatic vec_t v(input logic mg, input logic [N-1:0] en, input logic [N-1:0] rq,
                              input logic xr, input logic dn, input logic [N-1:0] pop,
                              input logic vld, input logic [IW-1:0] id,
                              input logic [N-1:0] busy, input logic [N-1:0] done);
      vec_t r;
      r.mg = mg; r.en = en; r.rq = rq; r.xr = xr; r.dn = dn;
      r.pop = pop; r.vld = vld; r.id = id; r.busy = busy; r.done = done;
      return r;
   endfunction

   typedef struct {
      logic [SA-1:0] src;
      logic [DA-1:0] dst;
      logic [LW-1:0] xl, yl, ss, ds;
   } desc_t;

   task automatic set_desc(input int c, input desc_t d);
      src_addr_i[c]   = d.src;
      dst_addr_i[c]   = d.dst;
      xfer_xlen_i[c]  = d.xl;
      xfer_ylen_i[c]  = d.yl;
      src_stride_i[c] = d.ss;
      dst_stride_i[c] = d.ds;
   endtask

   task automatic chk_fields(input string nm, input desc_t d);
      chk({nm, ".src"},  xfer_src_addr_o,        d.src);
      chk({nm, ".dst"},  xfer_dst_addr_o,        d.dst);
      chk({nm, ".xlen"}, 32'(xfer_xlen_o),       32'(d.xl));
      chk({nm, ".ylen"}, 32'(xfer_ylen_o),       32'(d.yl));
      chk({nm, ".sstr"}, 32'(xfer_src_stride_o), 32'(d.ss));
      chk({nm, ".dstr"}, 32'(xfer_dst_stride_o), 32'(d.ds));
   endtask

   task automatic chk_ctl(input string nm, input logic [N-1:0] pop, input logic vld,
                          input logic [N-1:0] busy, input logic [N-1:0] done);
      chk({nm, ".pop"},  32'(desc_rd_vld_o), 32'(pop));
      chk({nm, ".vld"},  32'(xfer_vld_o),    32'(vld));
      chk({nm, ".busy"}, 32'(chn_busy_o),    32'(busy));
      chk({nm, ".done"}, 32'(chn_done_o),    32'(done));
   endtask

   // Transaction-level reference: the descriptor currently owning the engine.
   typedef enum int {OFFERED, IN_ENGINE, REPORTING} life_t;
   int    m_owner;
   life_t m_life;
   int    m_last;
   desc_t m_desc;

   vec_t  tbl[$];
   desc_t d;

   initial begin
      // Every cycle below: drive inputs on the falling edge, check 1 ns later.
      rst_n = 1'b0; mgmt_en_i = 1'b1; chn_en_i = '1; desc_rd_rdy_i = '1;
      xfer_rdy_i = 1'b1; xfer_done_i = 1'b0;
      for (int c = 0; c < N; c++)
         set_desc(c, '{src: 32'h1000_0000 | c, dst: 32'h2000_0000 | c,
                       xl: 16'd8, yl: 16'd2, ss: 16'd4, ds: 16'd4});

      repeat (3) @(negedge clk);
      #1;
      chk_ctl("reset", '0, 1'b0, '0, '0);
      chk("reset.id", 32'(xfer_chn_id_o), 32'd0);
      chk_fields("reset", '{src: '0, dst: '0, xl: '0, yl: '0, ss: '0, ds: '0});
      @(negedge clk);
      rst_n = 1'b1;

      //        mg   en    rq    xr  dn  pop   vld id    busy  done
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h1, 0, 2'd0, 4'h0, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h0, 1, 2'd0, 4'h1, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 1, 4'h0, 0, 2'd0, 4'h1, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h0, 0, 2'd0, 4'h1, 4'h1));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h2, 0, 2'd0, 4'h0, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h0, 1, 2'd1, 4'h2, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 1, 4'h0, 0, 2'd1, 4'h2, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h0, 0, 2'd1, 4'h2, 4'h2));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h4, 0, 2'd1, 4'h0, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h0, 1, 2'd2, 4'h4, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 1, 4'h0, 0, 2'd2, 4'h4, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h0, 0, 2'd2, 4'h4, 4'h4));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h8, 0, 2'd2, 4'h0, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h0, 1, 2'd3, 4'h8, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 1, 4'h0, 0, 2'd3, 4'h8, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h0, 0, 2'd3, 4'h8, 4'h8));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h1, 0, 2'd3, 4'h0, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h0, 1, 2'd0, 4'h1, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 1, 4'h0, 0, 2'd0, 4'h1, 4'h0));
      tbl.push_back(v(1, 4'hF, 4'hF, 1, 0, 4'h0, 0, 2'd0, 4'h1, 4'h1));
      tbl.push_back(v(0, 4'hF, 4'hF, 1, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0));
      tbl.push_back(v(0, 4'hF, 4'hF, 1, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0));
      tbl.push_back(v(1, 4'hE, 4'h9, 1, 1, 4'h8, 0, 2'd0, 4'h0, 4'h0));
      tbl.push_back(v(1, 4'hE, 4'h9, 1, 0, 4'h0, 1, 2'd3, 4'h8, 4'h0));
      tbl.push_back(v(1, 4'hE, 4'h0, 1, 1, 4'h0, 0, 2'd3, 4'h8, 4'h0));
      tbl.push_back(v(1, 4'hE, 4'h9, 1, 0, 4'h0, 0, 2'd3, 4'h8, 4'h8));
      tbl.push_back(v(1, 4'hE, 4'h9, 1, 0, 4'h8, 0, 2'd3, 4'h0, 4'h0));
      tbl.push_back(v(1, 4'h0, 4'h9, 1, 0, 4'h0, 1, 2'd3, 4'h8, 4'h0));
      tbl.push_back(v(0, 4'h0, 4'h9, 1, 1, 4'h0, 0, 2'd3, 4'h8, 4'h0));
      tbl.push_back(v(0, 4'h0, 4'h9, 1, 0, 4'h0, 0, 2'd3, 4'h8, 4'h8));
      tbl.push_back(v(1, 4'h0, 4'h9, 1, 0, 4'h0, 0, 2'd3, 4'h0, 4'h0));

      foreach (tbl[i]) begin
         mgmt_en_i = tbl[i].mg; chn_en_i = tbl[i].en; desc_rd_rdy_i = tbl[i].rq;
         xfer_rdy_i = tbl[i].xr; xfer_done_i = tbl[i].dn;
         #1;
         chk_ctl($sformatf("vec%0d", i), tbl[i].pop, tbl[i].vld, tbl[i].busy, tbl[i].done);
         chk($sformatf("vec%0d.id", i), 32'(xfer_chn_id_o), 32'(tbl[i].id));
         @(negedge clk);
      end

      // Single channel with field check, done five cycles after accept.
      mgmt_en_i = 1'b1; chn_en_i = '1; xfer_done_i = 1'b0; xfer_rdy_i = 1'b1;
      d = '{src: 32'h1000, dst: 32'h2000, xl: 16'd16, yl: 16'd1, ss: 16'h40, ds: 16'h80};
      set_desc(2, d);
      desc_rd_rdy_i = 4'h4;
      #1 chk_ctl("single.t0", 4'h4, 1'b0, '0, '0);
      @(negedge clk); desc_rd_rdy_i = '0;
      #1 chk_ctl("single.t1", '0, 1'b1, 4'h4, '0);
      chk("single.id", 32'(xfer_chn_id_o), 32'd2);
      chk_fields("single", d);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1 chk_ctl($sformatf("single.wait%0d", k), '0, 1'b0, 4'h4, '0);
      end
      @(negedge clk); xfer_done_i = 1'b1;
      #1 chk_ctl("single.dn", '0, 1'b0, 4'h4, '0);
      @(negedge clk); xfer_done_i = 1'b0;
      #1 chk_ctl("single.report", '0, 1'b0, 4'h4, 4'h4);
      @(negedge clk);
      #1 chk_ctl("single.idle", '0, 1'b0, '0, '0);

      // Backpressure: offer held for 10 cycles, all other queues pending.
      d = '{src: 32'h3000_0003, dst: 32'h4000_0004, xl: 16'd5, yl: 16'd7, ss: 16'd9, ds: 16'd11};
      set_desc(1, d);
      desc_rd_rdy_i = 4'h2; xfer_rdy_i = 1'b0;
      #1 chk_ctl("bp.pop", 4'h2, 1'b0, '0, '0);
      @(negedge clk); desc_rd_rdy_i = '1;
      set_desc(1, '{src: '1, dst: '1, xl: '1, yl: '1, ss: '1, ds: '1});
      for (int k = 0; k < 10; k++) begin
         #1 chk_ctl($sformatf("bp.hold%0d", k), '0, 1'b1, 4'h2, '0);
         chk_fields($sformatf("bp.hold%0d", k), d);
         @(negedge clk);
      end
      xfer_rdy_i = 1'b1;
      #1 chk_ctl("bp.accept", '0, 1'b1, 4'h2, '0);
      @(negedge clk); xfer_rdy_i = 1'b0; xfer_done_i = 1'b1; desc_rd_rdy_i = '0;
      #1 chk_ctl("bp.busy", '0, 1'b0, 4'h2, '0);
      @(negedge clk); xfer_done_i = 1'b0;
      #1 chk_ctl("bp.report", '0, 1'b0, 4'h2, 4'h2);
      @(negedge clk);

      // Zero-length descriptor on channel 1.
      set_desc(1, '{src: 32'h55, dst: 32'h66, xl: 16'd0, yl: 16'd3, ss: 16'd1, ds: 16'd1});
      desc_rd_rdy_i = 4'h2; xfer_rdy_i = 1'b1;
      #1 chk_ctl("zl.pop", 4'h2, 1'b0, '0, '0);
      @(negedge clk); desc_rd_rdy_i = '0;
      #1 chk_ctl("zl.report", '0, 1'b0, 4'h2, 4'h2);
      @(negedge clk);
      #1 chk_ctl("zl.idle", '0, 1'b0, '0, '0);

      // Asynchronous reset while a descriptor is being offered.
      @(negedge clk);
      set_desc(0, '{src: 32'hABCD, dst: 32'h1234, xl: 16'd2, yl: 16'd2, ss: 16'd0, ds: 16'd0});
      desc_rd_rdy_i = 4'h1; xfer_rdy_i = 1'b0;
      #1 chk_ctl("arst.pop", 4'h1, 1'b0, '0, '0);
      @(negedge clk); desc_rd_rdy_i = '0;
      #1 chk_ctl("arst.offer", '0, 1'b1, 4'h1, '0);
      #1 rst_n = 1'b0;
      #1 chk_ctl("arst.cleared", '0, 1'b0, '0, '0);
      chk("arst.src", xfer_src_addr_o, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Randomized run against the transaction model.
      m_owner = -1; m_last = N - 1; m_life = OFFERED;
      m_desc  = '{src: '0, dst: '0, xl: '0, yl: '0, ss: '0, ds: '0};
      for (int cyc = 0; cyc < 1500; cyc++) begin
         logic [N-1:0] e_pop, e_busy, e_done, req;
         int g;
         mgmt_en_i     = ($urandom_range(7) != 0);
         for (int c = 0; c < N; c++) begin
            chn_en_i[c] = ($urandom_range(5) != 0);
            set_desc(c, '{src: $urandom, dst: $urandom,
                          xl: ($urandom_range(7) == 0) ? 16'd0 : LW'($urandom),
                          yl: ($urandom_range(7) == 0) ? 16'd0 : LW'($urandom),
                          ss: LW'($urandom), ds: LW'($urandom)});
         end
         desc_rd_rdy_i = N'($urandom);
         xfer_rdy_i    = ($urandom_range(2) == 0);
         xfer_done_i   = ($urandom_range(3) == 0);
         #1;
         req = desc_rd_rdy_i & chn_en_i;
         g = -1;
         if (m_owner < 0 && mgmt_en_i)
            for (int k = 1; k <= N; k++)
               if (g < 0 && req[(m_last + k) % N]) g = (m_last + k) % N;
         e_pop = '0; e_busy = '0; e_done = '0;
         if (g >= 0) e_pop[g] = 1'b1;
         if (m_owner >= 0) begin
            e_busy[m_owner] = 1'b1;
            if (m_life == REPORTING) e_done[m_owner] = 1'b1;
         end
         chk_ctl($sformatf("rnd%0d", cyc), e_pop, (m_owner >= 0 && m_life == OFFERED),
                 e_busy, e_done);
         if (m_owner >= 0 && m_life == OFFERED) begin
            chk($sformatf("rnd%0d.id", cyc), 32'(xfer_chn_id_o), 32'(m_owner));
            chk_fields($sformatf("rnd%0d", cyc), m_desc);
         end
         if (g >= 0) begin
            m_owner = g; m_last = g;
            m_desc  = '{src: src_addr_i[g], dst: dst_addr_i[g], xl: xfer_xlen_i[g],
                        yl: xfer_ylen_i[g], ss: src_stride_i[g], ds: dst_stride_i[g]};
            m_life  = (m_desc.xl == 0 || m_desc.yl == 0) ? REPORTING : OFFERED;
         end else if (m_owner >= 0) begin
            if (m_life == OFFERED && xfer_rdy_i)        m_life = IN_ENGINE;
            else if (m_life == IN_ENGINE && xfer_done_i) m_life = REPORTING;
            else if (m_life == REPORTING)                m_owner = -1;
         end
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
